// File: rtl/reset_sequencer.sv
// Board reset controller: merges PLL lock, a debounced push button and a software
// request into one reset cause, then releases NUM_DOMAINS resets in staggered order.
module reset_sequencer #(
   parameter int NUM_DOMAINS     = 3,
   parameter int HOLD_CYCLES     = 31,
   parameter int STAGGER_CYCLES  = 16,
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic                   clk,
   input  logic                   reset_n_i,
   input  logic                   locked_i,
   input  logic                   btn_n_i,
   input  logic                   sw_reset_i,
   output logic [NUM_DOMAINS-1:0] reset_o,
   output logic                   all_released_o,
   output logic [1:0]             cause_o
);

   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam int STAG_W = $clog2(STAGGER_CYCLES + 1);
   localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int REL_W  = $clog2(NUM_DOMAINS + 1);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'(STAGGER_CYCLES - 1);
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [REL_W-1:0]  REL_LAST  = REL_W'(NUM_DOMAINS - 1);
   localparam logic [REL_W-1:0]  REL_FIRST = REL_W'(1);

   localparam logic [1:0] CAUSE_POR  = 2'b00;
   localparam logic [1:0] CAUSE_LOCK = 2'b01;
   localparam logic [1:0] CAUSE_BTN  = 2'b10;
   localparam logic [1:0] CAUSE_SW   = 2'b11;

   typedef enum logic [1:0] {
      ST_ASSERT  = 2'b00,
      ST_RELEASE = 2'b01,
      ST_RUN     = 2'b10
   } state_e;

   state_e                   state_q, state_d;
   logic                     lock_meta_q, lock_meta_d;
   logic                     lock_sync_q, lock_sync_d;
   logic                     btn_meta_q, btn_meta_d;
   logic                     btn_sync_q, btn_sync_d;
   logic                     btn_deb_q, btn_deb_d;
   logic [DEB_W-1:0]         btn_cnt_q, btn_cnt_d;
   logic [HOLD_W-1:0]        hold_q, hold_d;
   logic [STAG_W-1:0]        stag_q, stag_d;
   logic [REL_W-1:0]         rel_q, rel_d;
   logic [NUM_DOMAINS-1:0]   reset_q, reset_d;
   logic                     all_rel_q, all_rel_d;
   logic [1:0]               cause_q, cause_d;
   logic                     lock_lost;
   logic                     btn_pressed;
   logic                     trigger;

   // Synchronisers and button debouncer (button value 1 = released).
   always_comb begin
      lock_meta_d = locked_i;
      lock_sync_d = lock_meta_q;
      btn_meta_d  = btn_n_i;
      btn_sync_d  = btn_meta_q;
      btn_deb_d   = btn_deb_q;
      btn_cnt_d   = '0;
      if (btn_sync_q != btn_deb_q) begin
         if (btn_cnt_q == DEB_LAST) begin
            btn_deb_d = btn_sync_q;
         end else begin
            btn_cnt_d = btn_cnt_q + 1'b1;
         end
      end else begin
         btn_cnt_d = '0;
      end
   end

   // Sequencer next state; rel counts how many domains are already released.
   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      stag_d      = stag_q;
      rel_d       = rel_q;
      cause_d     = cause_q;
      lock_lost   = ~lock_sync_q;
      btn_pressed = ~btn_deb_q;
      trigger     = lock_lost | btn_pressed | sw_reset_i;
      case (state_q)
         ST_ASSERT: begin
            stag_d = '0;
            rel_d  = '0;
            if (lock_sync_q && btn_deb_q) begin
               if (hold_q == HOLD_LAST) begin
                  hold_d  = '0;
                  rel_d   = REL_FIRST;
                  state_d = (NUM_DOMAINS == 1) ? ST_RUN : ST_RELEASE;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end else begin
               hold_d = '0;
            end
         end
         ST_RELEASE, ST_RUN: begin
            if (trigger) begin
               state_d = ST_ASSERT;
               hold_d  = '0;
               stag_d  = '0;
               rel_d   = '0;
               if (lock_lost) begin
                  cause_d = CAUSE_LOCK;
               end else if (btn_pressed) begin
                  cause_d = CAUSE_BTN;
               end else begin
                  cause_d = CAUSE_SW;
               end
            end else if (state_q == ST_RELEASE) begin
               if (stag_q == STAG_LAST) begin
                  stag_d = '0;
                  rel_d  = rel_q + 1'b1;
                  if (rel_q == REL_LAST) begin
                     state_d = ST_RUN;
                  end else begin
                     state_d = ST_RELEASE;
                  end
               end else begin
                  stag_d = stag_q + 1'b1;
               end
            end else begin
               stag_d = '0;
            end
         end
         default: begin
            state_d = ST_ASSERT;
            hold_d  = '0;
            stag_d  = '0;
            rel_d   = '0;
         end
      endcase
   end

   // Output decode from the next-state view so outputs change on the deciding edge.
   always_comb begin
      reset_d = '0;
      for (int k = 0; k < NUM_DOMAINS; k++) begin
         reset_d[k] = (k >= int'(rel_d));
      end
      all_rel_d = (state_d == ST_RUN);
   end

   // State, counter and output registers.
   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= ST_ASSERT;
         lock_meta_q <= 1'b0;
         lock_sync_q <= 1'b0;
         btn_meta_q  <= 1'b0;
         btn_sync_q  <= 1'b0;
         btn_deb_q   <= 1'b1;
         btn_cnt_q   <= '0;
         hold_q      <= '0;
         stag_q      <= '0;
         rel_q       <= '0;
         reset_q     <= '1;
         all_rel_q   <= 1'b0;
         cause_q     <= CAUSE_POR;
      end else begin
         state_q     <= state_d;
         lock_meta_q <= lock_meta_d;
         lock_sync_q <= lock_sync_d;
         btn_meta_q  <= btn_meta_d;
         btn_sync_q  <= btn_sync_d;
         btn_deb_q   <= btn_deb_d;
         btn_cnt_q   <= btn_cnt_d;
         hold_q      <= hold_d;
         stag_q      <= stag_d;
         rel_q       <= rel_d;
         reset_q     <= reset_d;
         all_rel_q   <= all_rel_d;
         cause_q     <= cause_d;
      end
   end

   assign reset_o        = reset_q;
   assign all_released_o = all_rel_q;
   assign cause_o        = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: vector table, directed corner sequences
// and random stimulus against a cycle-level behavioural model.
module tb_reset_sequencer;

   localparam int ND   = 3;
   localparam int HOLD = 4;
   localparam int STAG = 2;
   localparam int DEB  = 4;

   logic          clk = 1'b0;
   logic          reset_n_i;
   logic          locked_i;
   logic          btn_n_i;
   logic          sw_reset_i;
   logic [ND-1:0] reset_o;
   logic          all_released_o;
   logic [1:0]    cause_o;

   int total = 0;
   int bad   = 0;

   reset_sequencer #(
      .NUM_DOMAINS(ND), .HOLD_CYCLES(HOLD), .STAGGER_CYCLES(STAG), .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clk(clk), .reset_n_i(reset_n_i), .locked_i(locked_i), .btn_n_i(btn_n_i),
      .sw_reset_i(sw_reset_i), .reset_o(reset_o), .all_released_o(all_released_o),
      .cause_o(cause_o)
   );

   always #5 clk = ~clk;

   // Behavioural model: release progress is "cycles elapsed since release began".
   bit         m_l1, m_l2, m_b1, m_b2, m_deb, m_started;
   int         m_dcnt, m_hold, m_el;
   logic [1:0] m_cause;

   task automatic model_reset();
      m_l1 = 0; m_l2 = 0; m_b1 = 0; m_b2 = 0; m_deb = 1; m_started = 0;
      m_dcnt = 0; m_hold = 0; m_el = 0; m_cause = 2'b00;
   endtask

   task automatic model_edge();
      bit trig;
      trig = 0;
      if (!m_started) begin
         if (m_l2 && m_deb) begin
            m_hold++;
            if (m_hold == HOLD) begin m_started = 1; m_el = 0; m_hold = 0; end
         end else m_hold = 0;
      end else begin
         if (!m_l2)           m_cause = 2'b01;
         else if (!m_deb)     m_cause = 2'b10;
         else if (sw_reset_i) m_cause = 2'b11;
         trig = !m_l2 || !m_deb || sw_reset_i;
         if (trig) begin m_started = 0; m_hold = 0; end
         else if (m_el < (ND - 1) * STAG) m_el++;
      end
      if (m_b2 != m_deb) begin
         m_dcnt++;
         if (m_dcnt == DEB) begin m_deb = m_b2; m_dcnt = 0; end
      end else m_dcnt = 0;
      m_l2 = m_l1; m_l1 = locked_i;
      m_b2 = m_b1; m_b1 = btn_n_i;
   endtask

   function automatic logic [ND-1:0] exp_reset();
      logic [ND-1:0] r;
      for (int k = 0; k < ND; k++) r[k] = (!m_started || m_el < k * STAG);
      return r;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
      end
   endtask

   task automatic check_model();
      check("model reset_o", 32'(reset_o), 32'(exp_reset()));
      check("model all_released_o", 32'(all_released_o),
            32'(m_started && m_el >= (ND - 1) * STAG));
      check("model cause_o", 32'(cause_o), 32'(m_cause));
   endtask

   // Called at a negedge; returns at the following negedge.
   task automatic edge_only(input bit lk, input bit bn, input bit sw);
      locked_i = lk; btn_n_i = bn; sw_reset_i = sw;
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic step(input bit lk, input bit bn, input bit sw);
      edge_only(lk, bn, sw);
      check_model();
   endtask

   task automatic async_reset(input int hold_edges);
      reset_n_i = 1'b0;
      model_reset();
      #1;
      check("async reset_o", 32'(reset_o), 32'h7);
      check("async all_released_o", 32'(all_released_o), 32'h0);
      check("async cause_o", 32'(cause_o), 32'h0);
      repeat (hold_edges) @(negedge clk);
      reset_n_i = 1'b1;
   endtask

   typedef struct packed {
      logic          lk;
      logic          bn;
      logic          sw;
      logic [ND-1:0] rst;
      logic          all;
      logic [1:0]    cause;
   } vec_t;

   vec_t vecs [15];
   bit   bstate;

   initial begin
      // Power-on release, then a software reset in RUN and a second one in ASSERT.
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 3'b111, 1'b0, 2'b00};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 3'b111, 1'b0, 2'b00};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, 3'b111, 1'b0, 2'b00};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 3'b111, 1'b0, 2'b00};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 3'b111, 1'b0, 2'b00};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 3'b110, 1'b0, 2'b00};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 3'b110, 1'b0, 2'b00};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 3'b100, 1'b0, 2'b00};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 3'b100, 1'b0, 2'b00};
      vecs[9]  = '{1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 2'b00};
      vecs[10] = '{1'b1, 1'b1, 1'b1, 3'b111, 1'b0, 2'b11};
      vecs[11] = '{1'b1, 1'b1, 1'b1, 3'b111, 1'b0, 2'b11};
      vecs[12] = '{1'b1, 1'b1, 1'b0, 3'b111, 1'b0, 2'b11};
      vecs[13] = '{1'b1, 1'b1, 1'b0, 3'b111, 1'b0, 2'b11};
      vecs[14] = '{1'b1, 1'b1, 1'b0, 3'b110, 1'b0, 2'b11};

      reset_n_i = 1'b0; locked_i = 1'b1; btn_n_i = 1'b1; sw_reset_i = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset reset_o", 32'(reset_o), 32'h7);
      check("reset all_released_o", 32'(all_released_o), 32'h0);
      check("reset cause_o", 32'(cause_o), 32'h0);
      reset_n_i = 1'b1;

      for (int i = 0; i < 15; i++) begin
         edge_only(vecs[i].lk, vecs[i].bn, vecs[i].sw);
         check($sformatf("vec%0d reset_o", i), 32'(reset_o), 32'(vecs[i].rst));
         check($sformatf("vec%0d all_released_o", i), 32'(all_released_o), 32'(vecs[i].all));
         check($sformatf("vec%0d cause_o", i), 32'(cause_o), 32'(vecs[i].cause));
      end

      // Finish release, then a one-cycle lock glitch in RUN.
      repeat (6) step(1, 1, 0);
      step(0, 1, 0);
      step(1, 1, 0);
      check("glitch still released", 32'(reset_o), 32'h0);
      step(1, 1, 0);
      check("glitch reset_o", 32'(reset_o), 32'h7);
      check("glitch cause_o", 32'(cause_o), 32'h1);
      repeat (3) step(1, 1, 0);
      check("glitch hold", 32'(reset_o), 32'h7);
      step(1, 1, 0);
      check("glitch re-release", 32'(reset_o), 32'h6);

      // Short button pulse is filtered out.
      repeat (4) step(1, 1, 0);
      repeat (2) step(1, 0, 0);
      repeat (6) step(1, 1, 0);
      check("pulse reset_o", 32'(reset_o), 32'h0);
      check("pulse all_released_o", 32'(all_released_o), 32'h1);

      // Held button resets, then release requires debounce plus hold.
      repeat (10) step(1, 0, 0);
      check("button reset_o", 32'(reset_o), 32'h7);
      check("button cause_o", 32'(cause_o), 32'h2);
      repeat (9) step(1, 1, 0);
      check("button still held", 32'(reset_o), 32'h7);
      repeat (11) step(1, 1, 0);
      check("button run", 32'(all_released_o), 32'h1);

      // Software request in the same cycle synced lock drops: lock wins.
      step(0, 1, 0);
      step(0, 1, 0);
      step(0, 1, 1);
      check("simul cause_o", 32'(cause_o), 32'h1);
      check("simul reset_o", 32'(reset_o), 32'h7);

      // Async reset after domain 0 released, then the full sequence again.
      repeat (7) step(1, 1, 0);
      check("pre-async reset_o", 32'(reset_o), 32'h6);
      async_reset(2);
      repeat (10) step(1, 1, 0);
      check("repeat reset_o", 32'(reset_o), 32'h0);
      check("repeat all_released_o", 32'(all_released_o), 32'h1);
      check("repeat cause_o", 32'(cause_o), 32'h0);

      // Random stimulus against the model.
      bstate = 1;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 999) < 3) async_reset($urandom_range(1, 3));
         if ($urandom_range(0, 99) < 4) bstate = ~bstate;
         step($urandom_range(0, 99) < 97, bstate, $urandom_range(0, 99) < 2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
